calc_input_sequencer: RTL

Front-end controller for the simple calculator datapath. It collects operand A, operand B and the opcode from board switches across three Enter presses, then drives the calculator through one operation with a fixed burst of Confirm pulses. It waits for the calculator's Done, captures C and Flag, and supervises the run with a timeout and a user Clear. It sits between the debounced board buttons/switches and the calculator core.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_edge_detect.sv | 20 ++
 rtl/calc_input_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front-end and core:
// one-hot sequencer state encoding, state index constants and opcodes.
package calc_pkg;

    typedef enum logic [7:0] {
        S_IDLE    = 8'b0000_0001,
        S_LOAD_A  = 8'b0000_0010,
        S_LOAD_B  = 8'b0000_0100,
        S_LOAD_OP = 8'b0000_1000,
        S_ISSUE   = 8'b0001_0000,
        S_WAIT    = 8'b0010_0000,
        S_SHOW    = 8'b0100_0000,
        S_TIMEOUT = 8'b1000_0000
    } state_t;

    localparam logic [2:0] IDX_IDLE    = 3'd0;
    localparam logic [2:0] IDX_LOAD_A  = 3'd1;
    localparam logic [2:0] IDX_LOAD_B  = 3'd2;
    localparam logic [2:0] IDX_LOAD_OP = 3'd3;
    localparam logic [2:0] IDX_ISSUE   = 3'd4;
    localparam logic [2:0] IDX_WAIT    = 3'd5;
    localparam logic [2:0] IDX_SHOW    = 3'd6;
    localparam logic [2:0] IDX_TIMEOUT = 3'd7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/calc_edge_detect.sv
// Rising-edge detector for a synchronized button level.
// Ports: Clk, Reset (async, active-high), Level in, Rise out (one cycle).
module calc_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic Level,
    output logic Rise
);

    logic prev;

    // prev resets high so a button held through reset gives no event
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) prev <= 1'b1;
        else       prev <= Level;
    end

    assign Rise = Level & ~prev;

endmodule

// File: rtl/calc_input_sequencer.sv
// Collects A, B and opcode over three Enter presses, drives a Confirm burst,
// waits for Done with a timeout and captures the result.
// Ports: Clk, Reset, Sw, BtnEnter, BtnClear, CalcDone/CalcC/CalcFlag in;
// Ain, Bin, OpCode, Confirm, CalcReset, Result, ResultFlag, ResultValid,
// Busy, Timeout, Step out.
module calc_input_sequencer
    import calc_pkg::*;
#(
    parameter int CONFIRM_PULSES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Sw,
    input  logic        BtnEnter,
    input  logic        BtnClear,
    input  logic        CalcDone,
    input  logic [15:0] CalcC,
    input  logic        CalcFlag,
    output logic [15:0] Ain,
    output logic [15:0] Bin,
    output logic [1:0]  OpCode,
    output logic        Confirm,
    output logic        CalcReset,
    output logic [15:0] Result,
    output logic        ResultFlag,
    output logic        ResultValid,
    output logic        Busy,
    output logic        Timeout,
    output logic [2:0]  Step
);

    localparam int PW = $clog2(2 * CONFIRM_PULSES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [PW-1:0] PLAST = PW'(2 * CONFIRM_PULSES - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic          enter_ev;
    logic          clear_ev;

    calc_edge_detect u_enter (
        .Clk   (Clk),
        .Reset (Reset),
        .Level (BtnEnter),
        .Rise  (enter_ev)
    );

    calc_edge_detect u_clear (
        .Clk   (Clk),
        .Reset (Reset),
        .Level (BtnClear),
        .Rise  (clear_ev)
    );

    assign Busy = state[IDX_ISSUE] | state[IDX_WAIT];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            Step        <= IDX_IDLE;
            pcnt        <= '0;
            tcnt        <= '0;
            Ain         <= '0;
            Bin         <= '0;
            OpCode      <= OP_ADD;
            Confirm     <= 1'b0;
            CalcReset   <= 1'b0;
            Result      <= '0;
            ResultFlag  <= 1'b0;
            ResultValid <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            Confirm   <= 1'b0;
            CalcReset <= 1'b0;
            if (clear_ev) begin
                state       <= S_IDLE;
                Step        <= IDX_IDLE;
                pcnt        <= '0;
                tcnt        <= '0;
                Ain         <= '0;
                Bin         <= '0;
                OpCode      <= OP_ADD;
                Result      <= '0;
                ResultFlag  <= 1'b0;
                ResultValid <= 1'b0;
                Timeout     <= 1'b0;
                CalcReset   <= 1'b1;
            end else begin
                unique case (1'b1)
                    state[IDX_IDLE]: begin
                        if (enter_ev) begin
                            state <= S_LOAD_A;
                            Step  <= IDX_LOAD_A;
                        end
                    end
                    state[IDX_LOAD_A]: begin
                        if (enter_ev) begin
                            Ain   <= Sw;
                            state <= S_LOAD_B;
                            Step  <= IDX_LOAD_B;
                        end
                    end
                    state[IDX_LOAD_B]: begin
                        if (enter_ev) begin
                            Bin   <= Sw;
                            state <= S_LOAD_OP;
                            Step  <= IDX_LOAD_OP;
                        end
                    end
                    state[IDX_LOAD_OP]: begin
                        if (enter_ev) begin
                            OpCode  <= Sw[1:0];
                            pcnt    <= '0;
                            // first pulse lands in ISSUE cycle 0
                            Confirm <= 1'b1;
                            state   <= S_ISSUE;
                            Step    <= IDX_ISSUE;
                        end
                    end
                    state[IDX_ISSUE]: begin
                        if (pcnt == PLAST) begin
                            tcnt  <= '0;
                            state <= S_WAIT;
                            Step  <= IDX_WAIT;
                        end else begin
                            // odd count now means even cycle next
                            Confirm <= pcnt[0];
                            pcnt    <= pcnt + 1'b1;
                        end
                    end
                    state[IDX_WAIT]: begin
                        if (CalcDone) begin
                            Result      <= CalcC;
                            ResultFlag  <= CalcFlag;
                            ResultValid <= 1'b1;
                            state       <= S_SHOW;
                            Step        <= IDX_SHOW;
                        end else if (tcnt == TLAST) begin
                            Timeout   <= 1'b1;
                            CalcReset <= 1'b1;
                            state     <= S_TIMEOUT;
                            Step      <= IDX_TIMEOUT;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    state[IDX_SHOW]: begin
                        if (enter_ev) begin
                            Confirm     <= 1'b1;
                            ResultValid <= 1'b0;
                            state       <= S_LOAD_A;
                            Step        <= IDX_LOAD_A;
                        end
                    end
                    state[IDX_TIMEOUT]: begin
                        if (enter_ev) begin
                            Timeout <= 1'b0;
                            state   <= S_LOAD_A;
                            Step    <= IDX_LOAD_A;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        Step  <= IDX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
